// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the default operand width and the controller state encodings.
// Encoding 2'd3 is unused; the controller recovers from it to IDLE.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bit counter width: one bit more than needed to index WIDTH bits.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder, purely combinational.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit unsigned operands plus a
// carry-in, one bit per clock LSB first, through a single full_adder.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request, only honoured in IDLE
//   a, b   - operands, captured on accepted start
//   cin    - initial carry, captured on accepted start
//   busy   - high while bits are processed (registered)
//   done   - one-cycle result-valid pulse (registered)
//   sum    - result register (shows partial values while busy)
//   cout   - final carry-out
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             last_bit_s;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             busy_s;
  logic             done_s;

  // Final bit of the pass is being added this cycle.
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  full_adder u_full_adder (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
    end
  end

  // Datapath: operand capture, serial shift, carry and counter update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          // New bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
          sum     <= {fa_sum_s, sum[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_bit_s) begin
            cout <= fa_cout_s;
          end
        end
        default: begin
          // DONE and the unused encoding hold the datapath.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation; hold keeps start high until done is seen.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input bit hold, input string tag);
    logic [8:0] exp;
    int  lat, busy_cyc, both;
    bit  seen;
    exp = {1'b0, ta} + {1'b0, tb} + {8'h00, tc};
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start8 = 1'b0;
    lat = 0; busy_cyc = 0; both = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8 && done8) both++;
      if (done8) begin
        seen = 1'b1;
        start8 = 1'b0;
      end else if (busy8) begin
        busy_cyc++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd8);
    check({tag, "_busy_and_done"}, 64'(both), 64'd0);
    check({tag, "_sum"}, 64'(sum8), 64'(exp[7:0]));
    check({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
    // One cycle later: back in IDLE, done dropped, result held.
    @(negedge clk);
    check({tag, "_idle_flags"}, 64'({busy8, done8}), 64'd0);
    check({tag, "_sum_hold"}, 64'({cout8, sum8}), 64'(exp));
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     input string tag);
    logic [4:0] exp;
    int  lat, busy_cyc;
    bit  seen;
    exp = {1'b0, ta} + {1'b0, tb} + {4'h0, tc};
    @(negedge clk);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; busy_cyc = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done4) seen = 1'b1;
      else if (busy4) busy_cyc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd5);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd4);
    check({tag, "_sum"}, 64'(sum4), 64'(exp[3:0]));
    check({tag, "_cout"}, 64'(cout4), 64'(exp[4]));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    logic [7:0] ra, rb;
    logic       rc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs8", 64'({busy8, done8, cout8, sum8}), 64'd0);
    check("reset_outputs4", 64'({busy4, done4, cout4, sum4}), 64'd0);

    op8(8'h00, 8'h00, 1'b1, 1'b0, "zero_plus_cin");
    check("zero_plus_cin_value", 64'({cout8, sum8}), 64'h001);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    check("ff_plus_1_value", 64'({cout8, sum8}), 64'h100);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, "ff_ff_cin");
    check("ff_ff_cin_value", 64'({cout8, sum8}), 64'h1FF);
    op8(8'h5A, 8'h3C, 1'b0, 1'b1, "held_start");
    check("held_start_value", 64'({cout8, sum8}), 64'h096);

    // Abort in the 4th RUN cycle with an asynchronous reset.
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 64'(busy8), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) stray++;
    end
    check("abort_no_done", 64'(stray), 64'd0);
    op8(8'h12, 8'h34, 1'b0, 1'b0, "after_abort");
    check("after_abort_value", 64'({cout8, sum8}), 64'h046);

    op4(4'hF, 4'h1, 1'b1, "w4_f_1_cin");
    check("w4_f_1_cin_value", 64'({cout4, sum4}), 64'h11);
    op4(4'h7, 4'h8, 1'b0, "w4_7_8");
    check("w4_7_8_value", 64'({cout4, sum4}), 64'h0F);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      rc = 1'($urandom_range(1, 0));
      op8(ra, rb, rc, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
